mem_port_arbiter: RTL

Shares the single memory port of the memory subsystem among three requesters: the core data port, the core instruction-fetch port, and the MLP accelerator's weight/activation DMA port. It sits between the core/accelerator and the memory top, using the same req/ready handshake on every side. It latches one request at a time, forwards it to memory, and returns the response only to the owner. Arbitration is round-robin.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports and the shared memory port seen by
// mem_port_arbiter; slave is the arbiter's view, master is the environment's.
interface mem_port_arbiter_if #(
   parameter int DWIDTH = 32
);
   // Handshake: a requester raises *_req with stable write/addr/wdata and keeps
   // it high until its *_ready pulses for one cycle; *_rdata is meaningful only
   // while that *_ready is high. Toward memory, mem_req stays high with stable
   // fields until mem_ready is seen, and mem_ready outside a request is ignored.
   logic              d_req,   i_req,   a_req;
   logic              d_write, i_write, a_write;
   logic [DWIDTH-1:0] d_addr,  i_addr,  a_addr;
   logic [DWIDTH-1:0] d_wdata, i_wdata, a_wdata;
   logic              d_ready, i_ready, a_ready;
   logic [DWIDTH-1:0] d_rdata, i_rdata, a_rdata;

   logic              mem_req;
   logic              mem_write;
   logic [DWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_wdata;
   logic              mem_ready;
   logic [DWIDTH-1:0] mem_rdata;

   modport slave (
      input  d_req, i_req, a_req, d_write, i_write, a_write,
      input  d_addr, i_addr, a_addr, d_wdata, i_wdata, a_wdata,
      output d_ready, i_ready, a_ready, d_rdata, i_rdata, a_rdata,
      output mem_req, mem_write, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport master (
      output d_req, i_req, a_req, d_write, i_write, a_write,
      output d_addr, i_addr, a_addr, d_wdata, i_wdata, a_wdata,
      input  d_ready, i_ready, a_ready, d_rdata, i_rdata, a_rdata,
      input  mem_req, mem_write, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among core data (0), core fetch (1)
// and accelerator DMA (2); one latched transaction in flight at a time.
module mem_port_arbiter #(
   parameter int DWIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus,
   output logic                dbg_state
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state, state_next;
   logic [2:0]        req_v, eligible, mask_last;
   logic [1:0]        last, owner, winner, first, second;
   logic              grant, done;
   logic              write_sel;
   logic [DWIDTH-1:0] addr_sel, wdata_sel;

   logic              mem_req_q, mem_write_q;
   logic [DWIDTH-1:0] mem_addr_q, mem_wdata_q;

   function automatic logic [1:0] next_port(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign req_v    = {bus.a_req, bus.i_req, bus.d_req};
   // The previous owner may still hold req in the cycle after its completion.
   assign eligible = req_v & ~mask_last;
   assign first    = next_port(last);
   assign second   = next_port(first);

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      done       = 1'b0;
      winner     = 2'd0;
      case (state)
         IDLE: begin
            if (eligible[first]) begin
               grant  = 1'b1;
               winner = first;
            end else if (eligible[second]) begin
               grant  = 1'b1;
               winner = second;
            end else if (eligible[last]) begin
               grant  = 1'b1;
               winner = last;
            end
            if (grant) state_next = BUSY;
         end
         BUSY: begin
            if (bus.mem_ready) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The fetch port never writes, so its write strobe is tied low here.
   always_comb begin
      write_sel = 1'b0;
      addr_sel  = bus.d_addr;
      wdata_sel = bus.d_wdata;
      case (winner)
         2'd1: begin
            addr_sel  = bus.i_addr;
            wdata_sel = bus.i_wdata;
         end
         2'd2: begin
            write_sel = bus.a_write;
            addr_sel  = bus.a_addr;
            wdata_sel = bus.a_wdata;
         end
         default: begin
            write_sel = bus.d_write;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last        <= 2'd2;
         mask_last   <= 3'b000;
         owner       <= 2'd0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state     <= state_next;
         mask_last <= done ? (3'b001 << owner) : 3'b000;
         if (grant) begin
            owner       <= winner;
            mem_req_q   <= 1'b1;
            mem_write_q <= write_sel;
            mem_addr_q  <= addr_sel;
            mem_wdata_q <= wdata_sel;
         end else if (done) begin
            last        <= owner;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
         end
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // Completion and read data pass straight through from memory to the owner.
   assign bus.d_ready = done && (owner == 2'd0);
   assign bus.i_ready = done && (owner == 2'd1);
   assign bus.a_ready = done && (owner == 2'd2);
   assign bus.d_rdata = bus.mem_rdata;
   assign bus.i_rdata = bus.mem_rdata;
   assign bus.a_rdata = bus.mem_rdata;

   assign dbg_state = state;
endmodule
